// File: rtl/mux2_arbiter_if.sv
// Handshake bundle between two requesters, the round-robin arbiter and its downstream consumer.
// Latency: none (wires only).
// Backpressure: carries ready from downstream to the arbiter and ack back to each requester.
interface mux2_arbiter_if #(
    parameter int WIDTH = 32
);
    // Requester 0 side
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             ack0;

    // Requester 1 side
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             ack1;

    // Shared mux select and registered output towards the consumer
    logic             s;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             ready;

    // Requesters and consumer drive the inputs of the arbiter
    modport master (
        output req0,
        output data0,
        input  ack0,
        output req1,
        output data1,
        input  ack1,
        input  s,
        input  q,
        input  valid,
        output ready
    );

    // Arbiter view
    modport slave (
        input  req0,
        input  data0,
        output ack0,
        input  req1,
        input  data1,
        output ack1,
        output s,
        output q,
        output valid,
        input  ready
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin 2:1 arbiter driving a shared mux select and owning a registered valid/ready output word.
// Latency: one cycle from Ack to the word on Q with Valid = 1; one word per cycle sustained.
// Backpressure: Q/Valid hold while Valid && !Ready, no Ack is issued until space frees.
// Optional build macro ARB_GRANT_CNT_EN adds per-requester wrapping grant counters.
module mux2_arbiter #(
    parameter int WIDTH = 32
`ifdef ARB_GRANT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    mux2_arbiter_if.slave    bus
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt0_cnt_o,
    output logic [CNT_W-1:0] gnt1_cnt_o
`endif
);

    // Output register occupancy: EMPTY means Q carries nothing unconsumed
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             last_q,  last_d;
    logic [WIDTH-1:0] q_q,     q_d;

    logic             space;
    logic             sel;
    logic             ack0;
    logic             ack1;
    logic             any_ack;

    // Room for a new word: register empty, or its current word leaves this cycle
    always_comb begin : space_logic
        space = (state_q == ST_EMPTY) || bus.ready;
    end

    // Round-robin select: lone requester wins, contention goes to the one not served last,
    // idle holds the previous select so the shared mux does not toggle needlessly
    always_comb begin : select_logic
        sel = last_q;
        if (bus.req0 && bus.req1) begin
            sel = ~last_q;
        end else if (bus.req0) begin
            sel = 1'b0;
        end else if (bus.req1) begin
            sel = 1'b1;
        end
    end

    // Grants are gated by reset so no requester sees an accept while the block is held in reset
    always_comb begin : grant_logic
        ack0    = rst_ni && space && bus.req0 && (sel == 1'b0);
        ack1    = rst_ni && space && bus.req1 && (sel == 1'b1);
        any_ack = ack0 || ack1;
    end

    // Next-state: capture the selected word on a grant, otherwise drain on consumption
    always_comb begin : next_state_logic
        state_d = state_q;
        last_d  = last_q;
        q_d     = q_q;
        if (any_ack) begin
            q_d     = sel ? bus.data1 : bus.data0;
            state_d = ST_FULL;
            last_d  = sel;
        end else if ((state_q == ST_FULL) && bus.ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State registers; Last resets to 1 so the first contended grant goes to requester 0
    always_ff @(posedge clk_i or negedge rst_ni) begin : state_regs
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            last_q  <= 1'b1;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            q_q     <= q_d;
        end
    end

    // Drive the interface outputs
    always_comb begin : output_logic
        bus.ack0  = ack0;
        bus.ack1  = ack1;
        bus.s     = sel;
        bus.q     = q_q;
        bus.valid = (state_q == ST_FULL);
    end

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Grant counters advance on their own Ack and wrap naturally at 2^CNT_W
    always_comb begin : cnt_next_logic
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (ack0) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (ack1) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin : cnt_regs
        if (!rst_ni) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // Counter outputs
    always_comb begin : cnt_out_logic
        gnt0_cnt_o = cnt0_q;
        gnt1_cnt_o = cnt1_q;
    end
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: reference model plus a scoreboard queue of expected words.
// Latency: words are expected on Q one cycle after the model grants them.
// Backpressure: exercised with Ready held low while both requesters wait.
module tb_mux2_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;

    mux2_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] gnt0_cnt;
    logic [CNT_W-1:0] gnt1_cnt;
    logic [CNT_W-1:0] m_cnt0;
    logic [CNT_W-1:0] m_cnt1;

    mux2_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .gnt0_cnt_o (gnt0_cnt),
        .gnt1_cnt_o (gnt1_cnt)
    );
`else
    mux2_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic             m_last;
    logic             m_valid;
    logic [WIDTH-1:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_last  = 1'b1;
        m_valid = 1'b0;
        sb.delete();
`ifdef ARB_GRANT_CNT_EN
        m_cnt0 = '0;
        m_cnt1 = '0;
`endif
    endtask

    // Called at posedge+1 with inputs already driven; checks, then advances one clock.
    task automatic step();
        logic exp_s, exp_a0, exp_a1, space;
        #2;
        space = !m_valid || bus.ready;
        if (bus.req0 && bus.req1)  exp_s = !m_last;
        else if (bus.req0)         exp_s = 1'b0;
        else if (bus.req1)         exp_s = 1'b1;
        else                       exp_s = m_last;
        exp_a0 = space && bus.req0 && !exp_s;
        exp_a1 = space && bus.req1 && exp_s;

        checks++;
        if (bus.s !== exp_s) begin
            errors++; $display("FAIL sel: got %b expected %b", bus.s, exp_s);
        end
        checks++;
        if (bus.ack0 !== exp_a0) begin
            errors++; $display("FAIL ack0: got %b expected %b", bus.ack0, exp_a0);
        end
        checks++;
        if (bus.ack1 !== exp_a1) begin
            errors++; $display("FAIL ack1: got %b expected %b", bus.ack1, exp_a1);
        end
        checks++;
        if (bus.valid !== m_valid) begin
            errors++; $display("FAIL valid: got %b expected %b", bus.valid, m_valid);
        end
`ifdef ARB_GRANT_CNT_EN
        checks++;
        if (gnt0_cnt !== m_cnt0 || gnt1_cnt !== m_cnt1) begin
            errors++;
            $display("FAIL gnt_cnt: got %0d/%0d expected %0d/%0d", gnt0_cnt, gnt1_cnt, m_cnt0, m_cnt1);
        end
`endif
        if (m_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL scoreboard_empty: got q %h expected no word", bus.q);
            end else if (bus.q !== sb[0]) begin
                errors++; $display("FAIL q_word: got %h expected %h", bus.q, sb[0]);
            end
            if (bus.ready && sb.size() != 0) void'(sb.pop_front());
        end
        if (exp_a0) sb.push_back(bus.data0);
        if (exp_a1) sb.push_back(bus.data1);

        @(posedge clk);
        if (exp_a0 || exp_a1) begin
            m_valid = 1'b1;
            m_last  = exp_s;
        end else if (bus.ready) begin
            m_valid = 1'b0;
        end
`ifdef ARB_GRANT_CNT_EN
        if (exp_a0) m_cnt0 = m_cnt0 + 1'b1;
        if (exp_a1) m_cnt1 = m_cnt1 + 1'b1;
`endif
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;
        bus.ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Held in reset from time zero with both requesting
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.ready = 1'b1;
        #1;
        checks++;
        if (bus.q !== '0 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL reset_state: got q %h valid %b expected 0/0", bus.q, bus.valid);
        end
        checks++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            errors++; $display("FAIL reset_ack: got %b%b expected 00", bus.ack0, bus.ack1);
        end
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        step();
        // Load a word and leave it stalled
        bus.req0 = 1'b1; bus.data0 = 32'hDEADBEEF; bus.ready = 1'b0;
        step();
        bus.req0 = 1'b0;
        checks++;
        if (bus.q !== 32'hDEADBEEF || bus.valid !== 1'b1) begin
            errors++; $display("FAIL preload: got q %h valid %b expected deadbeef/1", bus.q, bus.valid);
        end
        // Asynchronous reset mid-cycle
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.q !== '0 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got q %h valid %b expected 0/0", bus.q, bus.valid);
        end
        checks++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            errors++; $display("FAIL async_reset_ack: got %b%b expected 00", bus.ack0, bus.ack1);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.data0 = 32'h1111_0000; bus.data1 = 32'h2222_0000;
        step();
        checks++;
        if (bus.q !== 32'h1111_0000) begin
            errors++; $display("FAIL first_contended: got %h expected 11110000", bus.q);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_single();
        bus.req0 = 1'b1; bus.data0 = 32'h0000_0011; bus.ready = 1'b1;
        step();
        bus.req0 = 1'b0;
        checks++;
        if (bus.q !== 32'h0000_0011 || bus.valid !== 1'b1 || bus.s !== 1'b0) begin
            errors++;
            $display("FAIL single: got q %h valid %b s %b expected 00000011/1/0", bus.q, bus.valid, bus.s);
        end
        step();
        step();
    endtask

    task automatic test_alternate();
        logic [WIDTH-1:0] exp_w;
        do_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.data0 = 32'hAAAA_0000; bus.data1 = 32'h0000_BBBB;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_w = (i % 2 == 0) ? 32'hAAAA_0000 : 32'h0000_BBBB;
            checks++;
            if (bus.q !== exp_w || bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL alternate[%0d]: got %h/%b expected %h/1", i, bus.q, bus.valid, exp_w);
            end
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_back_to_back_stall();
        logic [WIDTH-1:0] held_q;
        logic             held_s;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.data0 = 32'h0101_0101; bus.data1 = 32'h0202_0202;
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        held_q = 32'h0101_0101;
        held_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.q !== held_q || bus.valid !== 1'b1 || bus.s !== held_s) begin
                errors++;
                $display("FAIL stall[%0d]: got %h/%b/%b expected %h/1/%b", i, bus.q, bus.valid, bus.s, held_q, held_s);
            end
        end
        bus.ready = 1'b1;
        step();
        checks++;
        if (bus.q !== 32'h0202_0202) begin
            errors++; $display("FAIL stall_release: got %h expected 02020202", bus.q);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_req_drop();
        bus.req0 = 1'b1; bus.data0 = 32'h0000_0C0C; bus.ready = 1'b0;
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.data1 = 32'h0000_0D0D;
        step();
        bus.req1 = 1'b0;
        step();
        checks++;
        if (bus.s !== 1'b0) begin
            errors++; $display("FAIL req_drop_last: got s %b expected 0", bus.s);
        end
        bus.req0 = 1'b1; bus.data0 = 32'h0000_0E0E; bus.ready = 1'b1;
        step();
        bus.req0 = 1'b0;
        checks++;
        if (bus.q !== 32'h0000_0E0E) begin
            errors++; $display("FAIL req_drop_next: got %h expected 00000e0e", bus.q);
        end
        step();
        step();
    endtask

    task automatic test_grant_count();
        do_reset();
        bus.ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.req0  = 1'b1;
            bus.data0 = 32'h5000_0000 + i;
            step();
        end
        bus.req0 = 1'b0;
        checks++;
        if (bus.q !== 32'h5000_0010) begin
            errors++; $display("FAIL count_last_word: got %h expected 50000010", bus.q);
        end
        step();
`ifdef ARB_GRANT_CNT_EN
        checks++;
        if (gnt0_cnt !== 4'd1 || gnt1_cnt !== 4'd0) begin
            errors++; $display("FAIL count_wrap: got %0d/%0d expected 1/0", gnt0_cnt, gnt1_cnt);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_alternate();
        test_back_to_back_stall();
        test_req_drop();
        test_grant_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
